// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the CPU data-side responder: I/O address map,
// STATUS register layout and UART transmitter state encoding.
package data_bus_responder_pkg;

    localparam logic [15:0] ADDR_LED    = 16'hFF00;
    localparam logic [15:0] ADDR_TXDATA = 16'hFF01;
    localparam logic [15:0] ADDR_STATUS = 16'hFF02;
    localparam logic [15:0] ADDR_CYCLE  = 16'hFF03;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_OVERRUN_BIT = 1;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/data_bus_responder_uart_tx_core.sv
// 8N1 serial transmitter: owns the frame FSM, bit timer and shift register.
// The line output is registered so uart_tx never glitches between bits.
module uart_tx_core
    import data_bus_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    uart_state_t state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next;
    logic          bit_end;

    assign bit_end = (timer == TIMER_LAST);
    assign busy    = (state != UART_IDLE);

    always_comb begin
        state_next = state;
        timer_next = timer + 1'b1;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = 1'b1;
        case (state)
            UART_IDLE: begin
                timer_next = '0;
                if (start) begin
                    state_next = UART_START;
                    shift_next = data;
                    bit_next   = '0;
                end
            end
            UART_START: begin
                if (bit_end) begin
                    state_next = UART_DATA;
                    timer_next = '0;
                end
            end
            UART_DATA: begin
                if (bit_end) begin
                    timer_next = '0;
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = UART_STOP;
                    end
                end
            end
            UART_STOP: begin
                if (bit_end) begin
                    timer_next = '0;
                    state_next = UART_IDLE;
                end
            end
            default: state_next = UART_IDLE;
        endcase

        // Line level is derived from the state being entered so it lines up with it.
        case (state_next)
            UART_START: tx_next = 1'b0;
            UART_DATA:  tx_next = shift_next[0];
            default:    tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        shift <= shift_next;
        if (rst) begin
            state   <= UART_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_next;
            tx      <= tx_next;
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// CPU data-side target: word RAM plus memory-mapped LED, TXDATA, STATUS and
// CYCLE registers. Reads are combinational; writes commit on the rising edge.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int RAM_WORDS    = 4096,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] rdata,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [15:0] ram [RAM_WORDS];
    logic [15:0] cycle;
    logic [15:0] status;
    logic        overrun;
    logic        tx_busy;
    logic        ram_hit;
    logic [AW-1:0] ram_idx;
    logic        tx_write;
    logic        tx_start;
    logic        overrun_set;
    logic        overrun_clr;

    // Upper address bits must be zero: RAM does not alias across the map.
    assign ram_hit     = (addr[15:AW] == '0);
    assign ram_idx     = addr[AW-1:0];
    assign tx_write    = wr && (addr == ADDR_TXDATA);
    assign tx_start    = tx_write && !tx_busy && !rst;
    assign overrun_set = tx_write && tx_busy;
    assign overrun_clr = rd && (addr == ADDR_STATUS);

    always_comb begin
        status                     = '0;
        status[STATUS_BUSY_BIT]    = tx_busy;
        status[STATUS_OVERRUN_BIT] = overrun;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (ram_hit) begin
                rdata = ram[ram_idx];
            end else begin
                case (addr)
                    ADDR_LED:    rdata = {8'h00, leds};
                    ADDR_STATUS: rdata = status;
                    ADDR_CYCLE:  rdata = cycle;
                    default:     rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr && ram_hit && !rst) begin
            ram[ram_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds    <= '0;
            overrun <= 1'b0;
            cycle   <= '0;
        end else begin
            cycle <= cycle + 16'd1;
            if (wr && (addr == ADDR_LED)) begin
                leds <= wdata[7:0];
            end
            // A dropped byte on the same edge as a STATUS read must not be lost.
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_core (
        .clk  (clk),
        .rst  (rst),
        .start(tx_start),
        .data (wdata[7:0]),
        .busy (tx_busy),
        .tx   (uart_tx)
    );

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: table-driven bus accesses plus
// hand-written UART frame, overrun and mid-frame reset sequences.
module tb_data_bus_responder;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
    logic [15:0] rdata;
    logic [7:0]  leds;
    logic        uart_tx;

    int n_checks = 0;
    int n_fail   = 0;

    data_bus_responder #(
        .RAM_WORDS   (4096),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wdata  (wdata),
        .rd     (rd),
        .wr     (wr),
        .rdata  (rdata),
        .leds   (leds),
        .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [7:0]  exp_leds;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setin(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        rd    = r;
        wr    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Launch one frame of byte b; optionally inject an overrun write at
    // frame cycle ovr_at, or a reset (with a competing LED write) at rst_at.
    task automatic frame(input logic [7:0] b, input int ovr_at, input int rst_at);
        logic       eb;
        logic [15:0] exp_status;
        int         bit_no;
        setin(1'b0, 1'b1, 16'hFF01, {8'h00, b});
        @(negedge clk);
        chk("tx_idle_before_frame", {15'd0, uart_tx}, 16'h0001);
        next_cycle();
        for (int i = 0; i < 40; i++) begin
            bit_no = i / 4;
            if (bit_no == 0)      eb = 1'b0;
            else if (bit_no == 9) eb = 1'b1;
            else                  eb = b[bit_no - 1];
            if (i == rst_at) begin
                rst = 1'b1;
                setin(1'b0, 1'b1, 16'hFF00, 16'h00FF);
            end else if (i == ovr_at) begin
                setin(1'b0, 1'b1, 16'hFF01, 16'h005A);
            end else begin
                setin(1'b1, 1'b0, 16'hFF02, 16'h0000);
            end
            @(negedge clk);
            chk($sformatf("tx_bit_cycle%0d", i), {15'd0, uart_tx}, {15'd0, eb});
            if (i != rst_at && i != ovr_at) begin
                exp_status = (ovr_at >= 0 && i == ovr_at + 1) ? 16'h0003 : 16'h0001;
                chk($sformatf("status_busy_cycle%0d", i), rdata, exp_status);
            end
            next_cycle();
            if (i == rst_at) begin
                rst = 1'b0;
                break;
            end
        end
        setin(1'b1, 1'b0, 16'hFF02, 16'h0000);
        @(negedge clk);
        chk("status_after_frame", rdata, 16'h0000);
        chk("tx_after_frame", {15'd0, uart_tx}, 16'h0001);
        if (rst_at >= 0) begin
            chk("leds_after_mid_reset", {8'h00, leds}, 16'h0000);
        end
        next_cycle();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 16'h0010, 16'hAAAA, 16'hBEEF, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hAAAA, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 16'h0000, 16'h1111, 16'h0000, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 16'h1000, 16'h0000, 16'h0000, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h0000, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 16'hFF10, 16'h0000, 16'h0000, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 16'hFF00, 16'h1234, 16'h0000, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 16'hFF00, 16'h0000, 16'h0034, 8'h34};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111, 8'h34};
        vecs[11] = '{1'b0, 1'b1, 16'hFF02, 16'hFFFF, 16'h0000, 8'h34};
        vecs[12] = '{1'b0, 1'b1, 16'hFF03, 16'h1234, 16'h0000, 8'h34};
        vecs[13] = '{1'b1, 1'b0, 16'hFF02, 16'h0000, 16'h0000, 8'h34};
        vecs[14] = '{1'b1, 1'b0, 16'hFF01, 16'h0000, 16'h0000, 8'h34};
        vecs[15] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 8'h34};
        vecs[16] = '{1'b0, 1'b1, 16'hFFFF, 16'h5555, 16'h0000, 8'h34};
        vecs[17] = '{1'b1, 1'b0, 16'hFF00, 16'h0000, 16'h0034, 8'h34};

        rst = 1'b1;
        setin(1'b0, 1'b0, 16'h0000, 16'h0000);
        next_cycle();
        rst = 1'b0;

        setin(1'b1, 1'b0, 16'hFF03, 16'h0000);
        @(negedge clk);
        chk("reset_cycle", rdata, 16'h0000);
        chk("reset_leds", {8'h00, leds}, 16'h0000);
        chk("reset_uart_tx", {15'd0, uart_tx}, 16'h0001);
        next_cycle();
        @(negedge clk);
        chk("cycle_increment", rdata, 16'h0001);
        next_cycle();
        setin(1'b1, 1'b0, 16'hFF02, 16'h0000);
        @(negedge clk);
        chk("reset_status", rdata, 16'h0000);
        next_cycle();

        for (int v = 0; v < 18; v++) begin
            setin(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            @(negedge clk);
            chk($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
            chk($sformatf("vec%0d_leds", v), {8'h00, leds}, {8'h00, vecs[v].exp_leds});
            next_cycle();
        end

        frame(8'hA5, -1, -1);
        frame(8'hA5, 5, -1);
        frame(8'hA5, -1, 10);
        frame(8'h3C, -1, -1);

        setin(1'b0, 1'b0, 16'h0000, 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
